// File: rtl/aes_core_sequencer.sv
// AES-256 core sequencer behind the AXI4 slave register file.
// Buffers key and block words, runs key expansion only when the key changed or a
// rekey is forced, starts one block operation, captures the result and reports
// busy/done/error. Optional feature macro: AES_SEQ_IRQ_EN adds a one-cycle irq
// pulse whenever sts_done or sts_err rises.
module aes_core_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic         s00_axi_aclk,
    input  logic         s00_axi_areset,
    input  logic         cfg_wr_en,
    input  logic [3:0]   cfg_wr_addr,
    input  logic [31:0]  cfg_wr_data,
    input  logic         cmd_start,
    input  logic         cmd_decrypt,
    input  logic         cmd_rekey,
    input  logic         cmd_clear,
    output logic         sts_busy,
    output logic         sts_done,
    output logic         sts_err,
    input  logic [1:0]   res_rd_addr,
    output logic [31:0]  res_rd_data,
    output logic [255:0] core_key,
    output logic         core_key_load,
    input  logic         core_key_ready,
    output logic [127:0] core_din,
    output logic         core_decrypt,
    output logic         core_start,
    input  logic         core_done,
    input  logic [127:0] core_dout
`ifdef AES_SEQ_IRQ_EN
    ,
    output logic         irq
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StKeyLoad,
        StKeyWait,
        StStart,
        StRun,
        StDone,
        StErr
    } state_e;

    // Last waiting cycle before the timeout fires.
    localparam logic [CNT_W-1:0] TmoLast = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [255:0]       key_q;
    logic [127:0]       din_q;
    logic [127:0]       res_q;
    logic               key_dirty_q;
    logic               dec_q;
    logic               busy_q, done_q, err_q;
    logic               key_load_q, start_q;
    logic               accept, key_ack, res_we;

    // Next-state, timeout counter and single-cycle event decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        key_ack = 1'b0;
        res_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_start) begin
                    accept  = 1'b1;
                    state_d = (key_dirty_q || cmd_rekey) ? StKeyLoad : StStart;
                end
            end
            StKeyLoad: begin
                state_d = StKeyWait;
                cnt_d   = '0;
            end
            StKeyWait: begin
                if (core_key_ready) begin
                    key_ack = 1'b1;
                    state_d = StStart;
                end else if (cnt_q == TmoLast) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStart: begin
                state_d = StRun;
                cnt_d   = '0;
            end
            StRun: begin
                if (core_done) begin
                    res_we  = 1'b1;
                    state_d = StDone;
                end else if (cnt_q == TmoLast) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, buffers and registered status/strobe outputs.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            key_q       <= '0;
            din_q       <= '0;
            res_q       <= '0;
            key_dirty_q <= 1'b1;
            dec_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            key_load_q  <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_load_q <= (state_q == StKeyLoad);
            start_q    <= (state_q == StStart);

            // Buffers are frozen while an operation uses them.
            if (cfg_wr_en && !busy_q) begin
                if (!cfg_wr_addr[3]) begin
                    key_q[32*(7-int'(cfg_wr_addr[2:0])) +: 32] <= cfg_wr_data;
                    key_dirty_q <= 1'b1;
                end else if (!cfg_wr_addr[2]) begin
                    din_q[32*(3-int'(cfg_wr_addr[1:0])) +: 32] <= cfg_wr_data;
                end
            end

            if (key_ack) key_dirty_q <= 1'b0;

            // Clear first so a flag set in this same cycle is not lost.
            if (cmd_clear) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end

            if (accept) begin
                dec_q  <= cmd_decrypt;
                busy_q <= 1'b1;
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end

            if (res_we) res_q <= core_dout;

            if (state_q == StDone) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end

            // A failed expansion may have left the core's schedule corrupt.
            if (state_q == StErr) begin
                err_q       <= 1'b1;
                busy_q      <= 1'b0;
                key_dirty_q <= 1'b1;
            end
        end
    end

`ifdef AES_SEQ_IRQ_EN
    logic irq_q;

    // Pulse coincides with the cycle sts_done or sts_err rises.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (state_q == StDone) || (state_q == StErr);
        end
    end

    assign irq = irq_q;
`endif

    // Result word read mux, word 0 is the most significant.
    always_comb begin
        res_rd_data = res_q[32*(3-int'(res_rd_addr)) +: 32];
    end

    assign sts_busy      = busy_q;
    assign sts_done      = done_q;
    assign sts_err       = err_q;
    assign core_key      = key_q;
    assign core_key_load = key_load_q;
    assign core_din      = din_q;
    assign core_decrypt  = dec_q;
    assign core_start    = start_q;

endmodule

// File: tb/tb_aes_core_sequencer.sv
// Scoreboard bench for aes_core_sequencer: stimulus pushes expected completions,
// a monitor pops them when sts_done or sts_err rises. A behavioural core answers
// with the AES-256 known-answer vector.
module tb_aes_core_sequencer;

    localparam int unsigned TMO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_wr_en;
    logic [3:0]   cfg_wr_addr;
    logic [31:0]  cfg_wr_data;
    logic         cmd_start, cmd_decrypt, cmd_rekey, cmd_clear;
    logic         sts_busy, sts_done, sts_err;
    logic [1:0]   res_rd_addr;
    logic [31:0]  res_rd_data;
    logic [255:0] core_key;
    logic         core_key_load, core_key_ready;
    logic [127:0] core_din;
    logic         core_decrypt, core_start, core_done;
    logic [127:0] core_dout;
`ifdef AES_SEQ_IRQ_EN
    logic         irq;
`endif

    logic [255:0] key_v = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    logic [127:0] pt_v  = 128'h00112233445566778899aabbccddeeff;
    logic [127:0] ct_v  = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef struct {
        logic         err;
        logic [127:0] res;
    } exp_t;
    exp_t sb[$];

    int checks = 0, failures = 0;
    int n_keyload = 0, n_start = 0, n_irq = 0, completions = 0;
    logic         hang = 1'b0;
    logic         exp_dec = 1'b0;
    logic [127:0] exp_din = '0;

    always #5 clk = ~clk;

    aes_core_sequencer #(
        .TIMEOUT_CYCLES(TMO),
        .CNT_W(16)
    ) dut (
        .s00_axi_aclk(clk),
        .s00_axi_areset(rst),
        .cfg_wr_en(cfg_wr_en),
        .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_data(cfg_wr_data),
        .cmd_start(cmd_start),
        .cmd_decrypt(cmd_decrypt),
        .cmd_rekey(cmd_rekey),
        .cmd_clear(cmd_clear),
        .sts_busy(sts_busy),
        .sts_done(sts_done),
        .sts_err(sts_err),
        .res_rd_addr(res_rd_addr),
        .res_rd_data(res_rd_data),
        .core_key(core_key),
        .core_key_load(core_key_load),
        .core_key_ready(core_key_ready),
        .core_din(core_din),
        .core_decrypt(core_decrypt),
        .core_start(core_start),
        .core_done(core_done),
        .core_dout(core_dout)
`ifdef AES_SEQ_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Strobe counters sampled away from the active edge.
    always @(negedge clk) begin
        if (core_key_load) n_keyload++;
        if (core_start) n_start++;
`ifdef AES_SEQ_IRQ_EN
        if (irq) n_irq++;
`endif
    end

    // Behavioural AES core: known-answer lookup with fixed latencies.
    initial begin : core_model
        logic [127:0] din_s;
        logic         dec_s;
        core_key_ready = 1'b0;
        core_done      = 1'b0;
        core_dout      = '0;
        forever begin
            @(negedge clk);
            if (core_key_load) begin
                chk("core_key_at_load", core_key, key_v);
                repeat (2) @(negedge clk);
                core_key_ready = 1'b1;
                @(negedge clk);
                core_key_ready = 1'b0;
            end else if (core_start && !hang) begin
                chk("core_din_at_start", core_din, exp_din);
                din_s = core_din;
                dec_s = core_decrypt;
                repeat (3) @(negedge clk);
                chk("core_decrypt_run", core_decrypt, exp_dec);
                if (!dec_s && din_s == pt_v) core_dout = ct_v;
                else if (dec_s && din_s == ct_v) core_dout = pt_v;
                else core_dout = ~din_s;
                core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
            end
        end
    end

    // Monitor: on each completion pop the expectation and read back all result words.
    initial begin : monitor
        logic prev_done, prev_err;
        exp_t e;
        prev_done   = 1'b0;
        prev_err    = 1'b0;
        res_rd_addr = 2'd0;
        forever begin
            @(negedge clk);
            if ((sts_done && !prev_done) || (sts_err && !prev_err)) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_completion done=%0b err=%0b required=none",
                             sts_done, sts_err);
                end else begin
                    e = sb.pop_front();
                    completions++;
                    chk("sts_err", sts_err, e.err);
                    chk("sts_done", sts_done, !e.err);
                    chk("sts_busy_end", sts_busy, 1'b0);
                    for (int w = 0; w < 4; w++) begin
                        res_rd_addr = w[1:0];
                        #1;
                        chk("res_word", res_rd_data, e.res[127-32*w -: 32]);
                    end
                    res_rd_addr = 2'd0;
                end
            end
            prev_done = sts_done;
            prev_err  = sts_err;
        end
    end

    task automatic wr(input int a, input logic [31:0] d);
        @(negedge clk);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = a[3:0];
        cfg_wr_data = d;
        @(negedge clk);
        cfg_wr_en   = 1'b0;
    endtask

    task automatic start(input logic dec, input logic rekey, input logic clr,
                         input logic [127:0] din, input logic push,
                         input logic err_e, input logic [127:0] res_e);
        @(negedge clk);
        cmd_start   = 1'b1;
        cmd_decrypt = dec;
        cmd_rekey   = rekey;
        cmd_clear   = clr;
        exp_dec     = dec;
        exp_din     = din;
        if (push) sb.push_back('{err: err_e, res: res_e});
        @(negedge clk);
        cmd_start   = 1'b0;
        cmd_decrypt = 1'b0;
        cmd_rekey   = 1'b0;
        cmd_clear   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (sts_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sts_busy) begin
            failures++;
            $display("FAIL %s_idle_timeout busy=1 required=0", name);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"}, sts_busy, 1'b0);
        chk({name, "_done"}, sts_done, 1'b0);
        chk({name, "_err"}, sts_err, 1'b0);
        chk({name, "_key_load"}, core_key_load, 1'b0);
        chk({name, "_core_start"}, core_start, 1'b0);
        chk({name, "_decrypt"}, core_decrypt, 1'b0);
        chk({name, "_key"}, core_key, 256'h0);
        chk({name, "_din"}, core_din, 128'h0);
        chk({name, "_res"}, res_rd_data, 32'h0);
`ifdef AES_SEQ_IRQ_EN
        chk({name, "_irq"}, irq, 1'b0);
`endif
    endtask

    task automatic load_key_block(input logic [127:0] blk);
        for (int i = 0; i < 8; i++) wr(i, key_v[255-32*i -: 32]);
        for (int i = 0; i < 4; i++) wr(8 + i, blk[127-32*i -: 32]);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        int kl0, st0, n;
        rst = 1'b1;
        cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
        cmd_start = 1'b0; cmd_decrypt = 1'b0; cmd_rekey = 1'b0; cmd_clear = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // 1: first encrypt loads the key once, then starts once.
        load_key_block(pt_v);
        kl0 = n_keyload; st0 = n_start;
        start(1'b0, 1'b0, 1'b0, pt_v, 1'b1, 1'b0, ct_v);
        wait_idle("t1");
        chk("t1_keyload_count", n_keyload - kl0, 1);
        chk("t1_start_count", n_start - st0, 1);

        // 2: clean key skips expansion; core_start two cycles after cmd_start.
        kl0 = n_keyload;
        @(negedge clk);
        cmd_start = 1'b1;
        exp_dec = 1'b0; exp_din = pt_v;
        sb.push_back('{err: 1'b0, res: ct_v});
        @(negedge clk);
        cmd_start = 1'b0;
        chk("t2_core_start_early", core_start, 1'b0);
        @(negedge clk);
        chk("t2_core_start_2cyc", core_start, 1'b1);
        wait_idle("t2a");
        chk("t2_no_keyload", n_keyload - kl0, 0);
        kl0 = n_keyload;
        start(1'b0, 1'b1, 1'b0, pt_v, 1'b1, 1'b0, ct_v);
        wait_idle("t2b");
        chk("t2_rekey_keyload", n_keyload - kl0, 1);

        // 3: decrypt the ciphertext back.
        for (int i = 0; i < 4; i++) wr(8 + i, ct_v[127-32*i -: 32]);
        start(1'b1, 1'b0, 1'b0, ct_v, 1'b1, 1'b0, pt_v);
        wait_idle("t3");

        // 4: core never answers -> timeout error, result unchanged, key reloaded next.
        hang = 1'b1;
        st0 = n_start;
        start(1'b0, 1'b0, 1'b0, ct_v, 1'b1, 1'b1, pt_v);
        wait_idle("t4a");
        hang = 1'b0;
        chk("t4_start_count", n_start - st0, 1);
        chk("t4_sts_err", sts_err, 1'b1);
        kl0 = n_keyload;
        start(1'b1, 1'b0, 1'b0, ct_v, 1'b1, 1'b0, pt_v);
        wait_idle("t4b");
        chk("t4_reload_after_err", n_keyload - kl0, 1);

        // 5: write and start while busy are dropped; clear+start in idle is accepted.
        for (int i = 0; i < 4; i++) wr(8 + i, pt_v[127-32*i -: 32]);
        st0 = n_start;
        start(1'b0, 1'b0, 1'b0, pt_v, 1'b1, 1'b0, ct_v);
        cfg_wr_en = 1'b1; cfg_wr_addr = 4'd0; cfg_wr_data = 32'hdeadbeef;
        cmd_start = 1'b1;
        @(negedge clk);
        cfg_wr_en = 1'b0;
        cmd_start = 1'b0;
        wait_idle("t5a");
        chk("t5_single_start", n_start - st0, 1);
        chk("t5_key_unchanged", core_key[255:224], 32'h00010203);
        kl0 = n_keyload;
        @(negedge clk);
        cmd_start = 1'b1;
        cmd_clear = 1'b1;
        exp_dec = 1'b0; exp_din = pt_v;
        sb.push_back('{err: 1'b0, res: ct_v});
        @(negedge clk);
        cmd_start = 1'b0;
        cmd_clear = 1'b0;
        chk("t5_clear_start_busy", sts_busy, 1'b1);
        chk("t5_clear_start_done", sts_done, 1'b0);
        chk("t5_clear_start_err", sts_err, 1'b0);
        wait_idle("t5b");
        chk("t5_dirty_unchanged", n_keyload - kl0, 0);

        // 6: reset during RUN aborts; the late core_done is ignored.
        start(1'b0, 1'b0, 1'b0, pt_v, 1'b0, 1'b0, '0);
        n = 0;
        while (!core_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reached_run", core_start, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("t6_after_reset");
        repeat (10) @(negedge clk);
        chk("t6_no_done", sts_done, 1'b0);
        chk("t6_idle", sts_busy, 1'b0);
        load_key_block(pt_v);
        kl0 = n_keyload;
        start(1'b0, 1'b0, 1'b0, pt_v, 1'b1, 1'b0, ct_v);
        wait_idle("t6");
        chk("t6_keyload_after_reset", n_keyload - kl0, 1);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drain", sb.size(), 0);
`ifdef AES_SEQ_IRQ_EN
        chk("irq_pulse_count", n_irq, completions);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
